// File: rtl/peripheral_msi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_msi_pkg
// Description : Shared AHB-Lite constants, arbiter state encoding and the
//               fixed-burst beat-count helper for the MSI interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_msi_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWNED  = 2'd1,
    ARB_BURST  = 2'd2,
    ARB_LOCKED = 2'd3
  } arb_state_e;

  // Beats in a fixed-length burst; INCR is open-ended and reports 0.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_SINGLE:                beats = 5'd1;
      HBURST_INCR:                  beats = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_msi_arbiter_select.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_msi_arbiter_select
// Description : Combinational selector. Highest priority among eligible
//               requesters wins; ties resolved by searching upward from
//               'pointer' with wrap-around.
// Ports       : req        - request vector
//               prio       - per-master priority (larger wins)
//               pointer    - index where the tie-break search starts
//               exclude    - masters removed from this selection
//               sel_onehot - one-hot winner (zero when none)
//               sel_idx    - binary winner index
//               sel_valid  - a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_msi_arbiter_select #(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = 2,
  parameter int IDX_W         = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0]                    req,
  input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] prio,
  input  logic [IDX_W-1:0]                      pointer,
  input  logic [MASTERS-1:0]                    exclude,
  output logic [MASTERS-1:0]                    sel_onehot,
  output logic [IDX_W-1:0]                      sel_idx,
  output logic                                  sel_valid
);

  logic [MASTERS-1:0]       w_eligible;
  logic [PRIORITY_BITS-1:0] w_max_prio;

  always_comb begin : p_select
    int j;
    w_eligible = req & ~exclude;
    w_max_prio = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (w_eligible[i] && (prio[i] > w_max_prio)) begin
        w_max_prio = prio[i];
      end
    end

    sel_onehot = '0;
    sel_idx    = '0;
    sel_valid  = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      j = int'(pointer) + k;
      if (j >= MASTERS) begin
        j = j - MASTERS;
      end
      if (!sel_valid && w_eligible[j] && (prio[j] == w_max_prio)) begin
        sel_valid     = 1'b1;
        sel_onehot[j] = 1'b1;
        sel_idx       = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/peripheral_msi_arbiter_ahb.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_msi_arbiter_ahb
// Description : Per-slave-port AHB-Lite arbiter. Registers the address-phase
//               owner (grant), tracks the data-phase owner, and honours
//               priority, HMASTLOCK and fixed-length bursts with round-robin
//               among equal priorities.
//               Optional macro PERIPHERAL_MSI_ARB_TIMEOUT_EN: preempts an INCR
//               owner after TIMEOUT cycles of contention.
// Ports       : HCLK, HRESETn (async active-low)
//               mst_priority/mst_req/mst_HMASTLOCK - per-master inputs
//               slv_HTRANS/slv_HBURST - granted master's control, post-mux
//               slv_HREADY  - slave HREADYOUT feedback
//               grant/grant_idx - address-phase owner
//               data_owner  - data-phase owner
//               slv_HMASTLOCK - lock currently held
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_msi_arbiter_ahb
  import peripheral_msi_pkg::*;
#(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic                                  HCLK,
  input  logic                                  HRESETn,
  input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] mst_priority,
  input  logic [MASTERS-1:0]                    mst_req,
  input  logic [MASTERS-1:0]                    mst_HMASTLOCK,
  input  logic [1:0]                            slv_HTRANS,
  input  logic [2:0]                            slv_HBURST,
  input  logic                                  slv_HREADY,
  output logic [MASTERS-1:0]                    grant,
  output logic [$clog2(MASTERS)-1:0]            grant_idx,
  output logic [MASTERS-1:0]                    data_owner,
  output logic                                  slv_HMASTLOCK
);

  localparam int c_idx_w = $clog2(MASTERS);

  arb_state_e           r_state,      w_state_nxt;
  logic [MASTERS-1:0]   r_grant,      w_grant_nxt;
  logic [c_idx_w-1:0]   r_grant_idx,  w_grant_idx_nxt;
  logic [c_idx_w-1:0]   r_rr_ptr,     w_rr_ptr_nxt;
  logic [4:0]           r_beats,      w_beats_nxt;
  logic [MASTERS-1:0]   r_data_owner;

  logic                 w_rearb;
  logic                 w_to_expired;
  logic                 w_own_req;
  logic                 w_own_lock;
  logic [4:0]           w_burst_len;
  logic [MASTERS-1:0]   w_exclude;
  logic [MASTERS-1:0]   w_sel_onehot;
  logic [c_idx_w-1:0]   w_sel_idx;
  logic                 w_sel_valid;

  assign w_own_req   = |(mst_req & r_grant);
  assign w_own_lock  = |(mst_HMASTLOCK & r_grant);
  assign w_burst_len = burst_beats(slv_HBURST);
  // A timed-out owner sits out the selection it triggered.
  assign w_exclude   = w_to_expired ? r_grant : '0;

  peripheral_msi_arbiter_select #(
    .MASTERS       (MASTERS),
    .PRIORITY_BITS (PRIORITY_BITS),
    .IDX_W         (c_idx_w)
  ) u_select (
    .req        (mst_req),
    .prio       (mst_priority),
    .pointer    (r_rr_ptr),
    .exclude    (w_exclude),
    .sel_onehot (w_sel_onehot),
    .sel_idx    (w_sel_idx),
    .sel_valid  (w_sel_valid)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_beats_nxt     = r_beats;
    w_rearb         = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (slv_HREADY && (|mst_req)) begin
          w_rearb = 1'b1;
        end
      end
      ARB_OWNED: begin
        if (slv_HREADY) begin
          // Lock and fixed-burst starts keep the owner; they take precedence
          // over the NONSEQ rearbitration point.
          if ((slv_HTRANS == HTRANS_NONSEQ) && w_own_lock) begin
            w_state_nxt = ARB_LOCKED;
          end else if ((slv_HTRANS == HTRANS_NONSEQ) && (w_burst_len > 5'd1)) begin
            w_state_nxt = ARB_BURST;
            w_beats_nxt = w_burst_len - 5'd1;
          end else if ((slv_HTRANS == HTRANS_IDLE) || (slv_HTRANS == HTRANS_NONSEQ) ||
                       !w_own_req || w_to_expired) begin
            w_rearb = 1'b1;
          end
        end
      end
      ARB_BURST: begin
        if (slv_HREADY) begin
          case (slv_HTRANS)
            HTRANS_SEQ: begin
              if (r_beats <= 5'd1) begin
                w_rearb = 1'b1;
              end else begin
                w_beats_nxt = r_beats - 5'd1;
              end
            end
            HTRANS_BUSY: begin
              w_beats_nxt = r_beats;
            end
            default: begin
              // IDLE or NONSEQ: owner abandoned the burst early.
              w_rearb = 1'b1;
            end
          endcase
        end
      end
      ARB_LOCKED: begin
        if (slv_HREADY && !w_own_lock) begin
          w_rearb = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase

    if (w_rearb) begin
      w_beats_nxt = 5'd0;
      if (w_sel_valid) begin
        w_state_nxt     = ARB_OWNED;
        w_grant_nxt     = w_sel_onehot;
        w_grant_idx_nxt = w_sel_idx;
        w_rr_ptr_nxt    = (w_sel_idx == c_idx_w'(MASTERS - 1)) ? '0 : w_sel_idx + 1'b1;
      end else begin
        w_state_nxt     = ARB_IDLE;
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_rr_ptr     <= '0;
      r_beats      <= 5'd0;
      r_data_owner <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_beats     <= w_beats_nxt;
      // Data phase follows the address phase that just completed.
      if (slv_HREADY) begin
        r_data_owner <= r_grant;
      end
    end
  end

`ifdef PERIPHERAL_MSI_ARB_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              w_others_pending;

  assign w_others_pending = |(mst_req & ~r_grant);
  assign w_to_expired     = (r_state == ARB_OWNED) && (r_to_cnt == c_to_w'(TIMEOUT));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_to_cnt <= '0;
    end else if (w_rearb || (r_state != ARB_OWNED)) begin
      r_to_cnt <= '0;
    end else if ((slv_HBURST == HBURST_INCR) && w_others_pending &&
                 (r_to_cnt != c_to_w'(TIMEOUT))) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // Preemption is not built in: never expires (TIMEOUT referenced only to
  // keep the parameter bound).
  assign w_to_expired = 1'b0 && (TIMEOUT != 0);
`endif

  assign grant         = r_grant;
  assign grant_idx     = r_grant_idx;
  assign data_owner    = r_data_owner;
  assign slv_HMASTLOCK = (r_state == ARB_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_arbiter_ahb.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_msi_arbiter_ahb
// Description : Directed-vector bench for peripheral_msi_arbiter_ahb. Each
//               stimulus cycle pushes the outputs expected during that cycle;
//               a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_msi_arbiter_ahb;
  import peripheral_msi_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [2:0][1:0] prio;
  logic [2:0]      req;
  logic [2:0]      lock;
  logic [1:0]      trans;
  logic [2:0]      burst;
  logic            ready;
  logic [2:0]      grant;
  logic [1:0]      grant_idx;
  logic [2:0]      data_owner;
  logic            hmastlock;

  typedef struct {
    logic [2:0] grant;
    logic [1:0] idx;
    logic [2:0] downer;
    logic       lock;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  peripheral_msi_arbiter_ahb #(
    .MASTERS       (3),
    .PRIORITY_BITS (2),
    .TIMEOUT       (8)
  ) dut (
    .HCLK          (clk),
    .HRESETn       (rst_n),
    .mst_priority  (prio),
    .mst_req       (req),
    .mst_HMASTLOCK (lock),
    .slv_HTRANS    (trans),
    .slv_HBURST    (burst),
    .slv_HREADY    (ready),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .data_owner    (data_owner),
    .slv_HMASTLOCK (hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

  // One bus cycle: inputs applied just after the rising edge, plus the
  // outputs expected to be visible during this cycle.
  task automatic cyc(input logic rn, input logic [2:0] rq, input logic [2:0] lk,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rd,
                     input logic [2:0] eg, input logic [2:0] edo, input logic el,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; req = rq; lock = lk; trans = tr; burst = bu; ready = rd;
    e.grant = eg; e.idx = enc(eg); e.downer = edo; e.lock = el; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin : p_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({grant, grant_idx, data_owner, hmastlock} !== {e.grant, e.idx, e.downer, e.lock}) begin
          failures++;
          $display("FAIL %s: got grant=%b idx=%0d data_owner=%b lock=%b, expected grant=%b idx=%0d data_owner=%b lock=%b",
                   e.name, grant, grant_idx, data_owner, hmastlock, e.grant, e.idx, e.downer, e.lock);
        end
      end
    end
  end

  initial begin : p_stim
    rst_n = 1'b0; req = '0; lock = '0; trans = HTRANS_IDLE;
    burst = HBURST_SINGLE; ready = 1'b1;
    prio = {2'd1, 2'd1, 2'd1};
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state and test 1: equal priorities, round-robin rotation
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b000, 0, "reset_state");
    cyc(1, 3'b111, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b000, 0, "rr_first_req");
    cyc(1, 3'b111, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b001, 3'b000, 0, "rr_m0");
    cyc(1, 3'b111, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b010, 3'b001, 0, "rr_m1");
    cyc(1, 3'b111, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b100, 3'b010, 0, "rr_m2");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b001, 3'b100, 0, "rr_wrap_m0");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b001, 0, "rr_idle");

    // Test 2: priorities 0,3,1; master 1 joins later and takes over
    prio = {2'd1, 2'd3, 2'd0};
    cyc(1, 3'b101, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b000, 0, "pr_idle");
    cyc(1, 3'b101, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b100, 3'b000, 0, "pr_m2_wins");
    cyc(1, 3'b111, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b100, 3'b100, 0, "pr_m1_joins");
    cyc(1, 3'b111, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b010, 3'b100, 0, "pr_m1_granted");
    cyc(1, 3'b111, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b010, 3'b010, 0, "pr_m1_holds");
    cyc(1, 3'b101, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b010, 3'b010, 0, "pr_m1_drops");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b100, 3'b010, 0, "pr_back_m2");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b100, 0, "pr_idle_end");

    // Test 3: INCR4 by master 0 with BUSY and wait states; master 2 waits
    prio = {2'd1, 2'd1, 2'd1};
    cyc(1, 3'b001, 0, HTRANS_IDLE,   HBURST_INCR4,  1, 3'b000, 3'b000, 0, "b4_idle");
    cyc(1, 3'b001, 0, HTRANS_NONSEQ, HBURST_INCR4,  1, 3'b001, 3'b000, 0, "b4_nonseq");
    cyc(1, 3'b101, 0, HTRANS_SEQ,    HBURST_INCR4,  1, 3'b001, 3'b001, 0, "b4_beat1");
    cyc(1, 3'b101, 0, HTRANS_BUSY,   HBURST_INCR4,  1, 3'b001, 3'b001, 0, "b4_busy");
    cyc(1, 3'b101, 0, HTRANS_SEQ,    HBURST_INCR4,  0, 3'b001, 3'b001, 0, "b4_wait1");
    cyc(1, 3'b101, 0, HTRANS_SEQ,    HBURST_INCR4,  0, 3'b001, 3'b001, 0, "b4_wait2");
    cyc(1, 3'b101, 0, HTRANS_SEQ,    HBURST_INCR4,  1, 3'b001, 3'b001, 0, "b4_beat2");
    cyc(1, 3'b101, 0, HTRANS_SEQ,    HBURST_INCR4,  1, 3'b001, 3'b001, 0, "b4_beat3");
    cyc(1, 3'b100, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b100, 3'b001, 0, "b4_handover");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b100, 3'b100, 0, "b4_m2_data");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b100, 0, "b4_idle_end");

    // Test 4: master 1 locked against higher-priority master 2
    prio = {2'd2, 2'd1, 2'd0};
    cyc(1, 3'b010, 3'b010, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b000, 0, "lk_idle");
    cyc(1, 3'b110, 3'b010, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b010, 3'b000, 0, "lk_xfer1");
    cyc(1, 3'b110, 3'b010, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b010, 3'b010, 1, "lk_xfer2");
    cyc(1, 3'b110, 3'b010, HTRANS_NONSEQ, HBURST_SINGLE, 0, 3'b010, 3'b010, 1, "lk_xfer3_wait");
    cyc(1, 3'b110, 3'b000, HTRANS_IDLE,   HBURST_SINGLE, 0, 3'b010, 3'b010, 1, "lk_drop_notready");
    cyc(1, 3'b100, 3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b010, 3'b010, 1, "lk_drop_ready");
    cyc(1, 3'b100, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b100, 3'b010, 0, "lk_released");

    // Test 5: asynchronous reset in the middle of a WRAP8
    cyc(1, 3'b100, 0, HTRANS_NONSEQ, HBURST_WRAP8,  1, 3'b100, 3'b100, 0, "rs_wrap8_start");
    cyc(1, 3'b101, 0, HTRANS_SEQ,    HBURST_WRAP8,  1, 3'b100, 3'b100, 0, "rs_wrap8_beat");
    cyc(0, 3'b101, 0, HTRANS_SEQ,    HBURST_WRAP8,  1, 3'b000, 3'b000, 0, "rs_async_zero");
    cyc(1, 3'b101, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b000, 0, "rs_released");
    cyc(1, 3'b101, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b100, 3'b000, 0, "rs_fresh_m2");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b100, 3'b100, 0, "rs_m2_data");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b000, 3'b100, 0, "rs_idle");

`ifdef PERIPHERAL_MSI_ARB_TIMEOUT_EN
    // Test 6: INCR owner preempted after TIMEOUT=8 contended cycles
    prio = {2'd1, 2'd1, 2'd1};
    cyc(1, 3'b001, 0, HTRANS_IDLE,   HBURST_INCR, 1, 3'b000, 3'b000, 0, "to_idle");
    cyc(1, 3'b001, 0, HTRANS_NONSEQ, HBURST_INCR, 1, 3'b001, 3'b000, 0, "to_nonseq");
    for (int k = 0; k < 9; k++) begin
      cyc(1, 3'b011, 0, HTRANS_SEQ,  HBURST_INCR, 1, 3'b001, 3'b001, 0, "to_stream");
    end
    cyc(1, 3'b010, 0, HTRANS_NONSEQ, HBURST_SINGLE, 1, 3'b010, 3'b001, 0, "to_preempted");
    cyc(1, 3'b000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 3'b010, 3'b010, 0, "to_m1_data");
`endif

    @(posedge clk);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
